// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped write-back data cache.
// Module parameters take their defaults from here.
package dcache_pkg;

  localparam int DEF_LINES      = 16;
  localparam int DEF_LINE_BITS  = 256;
  localparam int DEF_ADDR_W     = 32;
  localparam int WORD_W         = 32;
  localparam int OFFSET_W       = $clog2(DEF_LINE_BITS / 8);
  localparam int INDEX_W        = $clog2(DEF_LINES);
  localparam int TAG_W          = DEF_ADDR_W - INDEX_W - OFFSET_W;
  localparam int WORDS_PER_LINE = DEF_LINE_BITS / WORD_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    REFILL    = 2'd3
  } dc_state_e;

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side signals of the data cache.
// The master modport is the pipeline/memory environment; the slave modport is the controller.
interface dcache_if import dcache_pkg::*; #(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int LINE_BITS = DEF_LINE_BITS
);

  logic                 cpu_req_i;
  logic                 cpu_we_i;
  logic [ADDR_W-1:0]    cpu_addr_i;
  logic [WORD_W-1:0]    cpu_data_i;
  logic [WORD_W-1:0]    cpu_data_o;
  logic                 cpu_stall_o;
  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [ADDR_W-1:0]    mem_addr_o;
  logic [LINE_BITS-1:0] mem_data_o;
  logic [LINE_BITS-1:0] mem_data_i;
  logic                 mem_ack_i;

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
  );

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
  );

endinterface

// File: rtl/dcache_array.sv
// Register-based line storage: async read by index, sync line fill or single-word write.
// Reset clears only valid/dirty; tag and data contents are left as they are.
module dcache_array import dcache_pkg::*; #(
  parameter  int LINES     = DEF_LINES,
  parameter  int LINE_BITS = DEF_LINE_BITS,
  parameter  int TG_W      = TAG_W,
  localparam int IDX_W     = $clog2(LINES),
  localparam int SEL_W     = $clog2(LINE_BITS / WORD_W)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IDX_W-1:0]     rd_index,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [TG_W-1:0]      rd_tag,
  output logic [LINE_BITS-1:0] rd_line,
  input  logic [IDX_W-1:0]     wr_index,
  input  logic                 fill_en,
  input  logic [TG_W-1:0]      fill_tag,
  input  logic [LINE_BITS-1:0] fill_line,
  input  logic                 word_en,
  input  logic [SEL_W-1:0]     word_sel,
  input  logic [WORD_W-1:0]    word_data
);

  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;
  logic [TG_W-1:0]      tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[wr_index] <= 1'b1;
      dirty_q[wr_index] <= 1'b0;
    end else if (word_en) begin
      dirty_q[wr_index] <= 1'b1;
    end
  end

  // Fill wins over a word write; the controller never asserts both together.
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      tag_q[wr_index]  <= fill_tag;
      data_q[wr_index] <= fill_line;
    end else if (word_en) begin
      data_q[wr_index][{word_sel, 5'b0} +: WORD_W] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// MEM-stage direct-mapped write-back/write-allocate data cache controller.
// Generates Mem_stall and runs write-back/fetch over a line-wide req/ack memory port.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | hit check; loads/stores served in the same cycle on a hit
//   WRITEBACK | dirty victim line being written to memory, wait for ack
//   ALLOCATE  | requested line being fetched, filled into the array on ack
//   REFILL    | one settle cycle, then the held request hits in IDLE
module dcache_controller import dcache_pkg::*; #(
  parameter int LINES     = DEF_LINES,
  parameter int LINE_BITS = DEF_LINE_BITS,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input logic     clk_i,
  input logic     rst_i,
  dcache_if.slave bus
);

  localparam int OFF_W = $clog2(LINE_BITS / 8);
  localparam int IDX_W = $clog2(LINES);
  localparam int TG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int SEL_W = $clog2(LINE_BITS / WORD_W);

  dc_state_e state_q, state_d;

  logic [IDX_W-1:0]     cpu_index;
  logic [TG_W-1:0]      cpu_tag;
  logic [SEL_W-1:0]     cpu_sel;
  logic                 rd_valid, rd_dirty;
  logic [TG_W-1:0]      rd_tag;
  logic [LINE_BITS-1:0] rd_line;
  logic                 hit;
  logic                 fill_en, word_en;
  logic                 stall;
  logic [WORD_W-1:0]    cpu_data;
  logic                 mem_req, mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [LINE_BITS-1:0] mem_data;
  logic                 unused_addr_lsb;

  assign cpu_index       = bus.cpu_addr_i[OFF_W +: IDX_W];
  assign cpu_tag         = bus.cpu_addr_i[ADDR_W-1 -: TG_W];
  assign cpu_sel         = bus.cpu_addr_i[2 +: SEL_W];
  assign unused_addr_lsb = ^bus.cpu_addr_i[1:0];

  dcache_array #(
    .LINES     (LINES),
    .LINE_BITS (LINE_BITS),
    .TG_W      (TG_W)
  ) u_array (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rd_index  (cpu_index),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .wr_index  (cpu_index),
    .fill_en   (fill_en),
    .fill_tag  (cpu_tag),
    .fill_line (bus.mem_data_i),
    .word_en   (word_en),
    .word_sel  (cpu_sel),
    .word_data (bus.cpu_data_i)
  );

  assign hit = bus.cpu_req_i & rd_valid & (rd_tag == cpu_tag);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Memory outputs are decoded from state alone, so they drop the moment reset hits.
  always_comb begin
    state_d  = state_q;
    stall    = (state_q != IDLE) | (bus.cpu_req_i & ~hit);
    cpu_data = '0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    fill_en  = 1'b0;
    word_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req_i) begin
          if (hit) begin
            if (bus.cpu_we_i) word_en  = 1'b1;
            else              cpu_data = rd_line[{cpu_sel, 5'b0} +: WORD_W];
          end else if (rd_valid & rd_dirty) begin
            state_d = WRITEBACK;
          end else begin
            state_d = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {rd_tag, cpu_index, {OFF_W{1'b0}}};
        mem_data = rd_line;
        if (bus.mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req  = 1'b1;
        mem_addr = {cpu_tag, cpu_index, {OFF_W{1'b0}}};
        if (bus.mem_ack_i) begin
          fill_en = 1'b1;
          state_d = REFILL;
        end
      end
      REFILL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.cpu_stall_o = stall;
  assign bus.cpu_data_o  = cpu_data;
  assign bus.mem_req_o   = mem_req;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_data_o  = mem_data;

endmodule
